bcd_alu_seq: RTL and testbench

Multi-cycle sequencer for the calculator arithmetic path. It accepts an opcode and two 4-digit BCD operands from the keypad input stage and runs add, subtract, multiply or divide on a single shared one-digit BCD adder/subtractor, one digit per clock. It returns a BCD result, a remainder and status flags, which the display logic and the input stage consume.

---
 rtl/bcd_alu_seq.sv | 266 ++++++++++++++++++++++++++
 tb/tb_bcd_alu_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_alu_seq.sv
// Multi-cycle 4-digit BCD calculator ALU: add/sub/mul/div on one shared digit adder/subtractor,
// one digit per clock, LSD first, carry/borrow held between digits.
module bcd_alu_seq (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [15:0] bcd_a,
  input  logic [15:0] bcd_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [15:0] remainder,
  output logic        neg,
  output logic        ovf,
  output logic        err
);

  localparam logic [3:0] OP_ADD = 4'd10;
  localparam logic [3:0] OP_SUB = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [3:0] OP_DIV = 4'd13;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_PASS,
    S_SUB_BA,
    S_MUL_SHIFT,
    S_MUL_PASS,
    S_DIV_SHIFT,
    S_DIV_TRIAL,
    S_DONE
  } state_t;

  state_t      state_q, state_d;

  logic [3:0]  op_q;
  logic [15:0] a_q, b_q;
  logic [15:0] acc_q;
  logic [19:0] rem_q;
  logic [15:0] tmp_q;
  logic [2:0]  cnt_q;
  logic [1:0]  dig_q;
  logic [3:0]  reps_q;
  logic        carry_q;
  logic        ovf_q, neg_q, err_q;

  logic [15:0] res_h, rem_h;
  logic        neg_h, ovf_h, err_h;

  function automatic logic [3:0] dig(input logic [15:0] v, input logic [1:0] k);
    return v[{k, 2'b00} +: 4];
  endfunction

  function automatic logic bad_bcd(input logic [15:0] v);
    return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v[11:8] > 4'd9) || (v[15:12] > 4'd9);
  endfunction

  logic [1:0] k;
  logic       last_pass, last_trial, chk_err;
  logic [3:0] b_dig;

  assign k          = cnt_q[1:0];
  assign last_pass  = (cnt_q == 3'd3);
  assign last_trial = (cnt_q == 3'd4);
  assign b_dig      = dig(b_q, dig_q);
  assign chk_err    = (op_q < OP_ADD) || (op_q > OP_DIV) || bad_bcd(a_q) || bad_bcd(b_q) ||
                      ((op_q == OP_DIV) && (b_q == '0));

  // Shared one-digit BCD adder/subtractor
  logic [3:0] du_x, du_y, du_d;
  logic       du_sub, du_cin, du_cout;
  logic [4:0] du_raw;

  always_comb begin
    du_x   = '0;
    du_y   = '0;
    du_sub = 1'b0;
    case (state_q)
      S_PASS: begin
        du_x   = dig(a_q, k);
        du_y   = dig(b_q, k);
        du_sub = (op_q == OP_SUB);
      end
      S_SUB_BA: begin
        du_x   = dig(b_q, k);
        du_y   = dig(a_q, k);
        du_sub = 1'b1;
      end
      S_MUL_PASS: begin
        du_x = dig(acc_q, k);
        du_y = dig(a_q, k);
      end
      S_DIV_TRIAL: begin
        du_x   = rem_q[{cnt_q, 2'b00} +: 4];
        du_y   = last_trial ? 4'd0 : dig(b_q, k);
        du_sub = 1'b1;
      end
      default: ;
    endcase
  end

  assign du_cin = (cnt_q != 3'd0) && carry_q;

  always_comb begin
    if (du_sub) begin
      du_raw  = {1'b0, du_x} - {1'b0, du_y} - {4'd0, du_cin};
      du_cout = du_raw[4];
      du_d    = du_raw[4] ? du_raw[3:0] + 4'd10 : du_raw[3:0];
    end else begin
      du_raw  = {1'b0, du_x} + {1'b0, du_y} + {4'd0, du_cin};
      du_cout = (du_raw > 5'd9);
      du_d    = du_cout ? du_raw[3:0] + 4'd6 : du_raw[3:0];
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: begin
        if (chk_err) begin
          state_d = S_DONE;
        end else begin
          case (op_q)
            OP_MUL:  state_d = S_MUL_SHIFT;
            OP_DIV:  state_d = S_DIV_SHIFT;
            default: state_d = S_PASS;
          endcase
        end
      end
      S_PASS: begin
        if (last_pass) state_d = ((op_q == OP_SUB) && du_cout) ? S_SUB_BA : S_DONE;
      end
      S_SUB_BA: if (last_pass) state_d = S_DONE;
      S_MUL_SHIFT: begin
        if (b_dig != 4'd0)       state_d = S_MUL_PASS;
        else if (dig_q == 2'd0)  state_d = S_DONE;
      end
      S_MUL_PASS: begin
        if (last_pass && (reps_q == 4'd1)) state_d = (dig_q == 2'd0) ? S_DONE : S_MUL_SHIFT;
      end
      S_DIV_SHIFT: state_d = S_DIV_TRIAL;
      S_DIV_TRIAL: begin
        if (last_trial && du_cout) state_d = (dig_q == 2'd0) ? S_DONE : S_DIV_SHIFT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      tmp_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      reps_q  <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      res_h   <= '0;
      rem_h   <= '0;
      neg_h   <= 1'b0;
      ovf_h   <= 1'b0;
      err_h   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= opcode;
            a_q     <= bcd_a;
            b_q     <= bcd_b;
            acc_q   <= '0;
            rem_q   <= '0;
            tmp_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= 2'd3;
            reps_q  <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        S_CHECK: err_q <= chk_err;
        S_PASS, S_SUB_BA: begin
          acc_q[{k, 2'b00} +: 4] <= du_d;
          carry_q <= du_cout;
          cnt_q   <= last_pass ? 3'd0 : cnt_q + 3'd1;
          if (last_pass && du_cout && (state_q == S_PASS)) begin
            if (op_q == OP_ADD) ovf_q <= 1'b1;
            if (op_q == OP_SUB) neg_q <= 1'b1;
          end
        end
        S_MUL_SHIFT: begin
          if (acc_q[15:12] != 4'd0) ovf_q <= 1'b1;
          acc_q  <= {acc_q[11:0], 4'd0};
          reps_q <= b_dig;
          cnt_q  <= '0;
          if (b_dig == 4'd0) dig_q <= dig_q - 2'd1;
        end
        S_MUL_PASS: begin
          acc_q[{k, 2'b00} +: 4] <= du_d;
          carry_q <= du_cout;
          cnt_q   <= last_pass ? 3'd0 : cnt_q + 3'd1;
          if (last_pass) begin
            if (du_cout) ovf_q <= 1'b1;
            reps_q <= reps_q - 4'd1;
            if (reps_q == 4'd1) dig_q <= dig_q - 2'd1;
          end
        end
        S_DIV_SHIFT: begin
          rem_q <= {rem_q[15:0], dig(a_q, dig_q)};
          acc_q <= {acc_q[11:0], 4'd0};
          cnt_q <= '0;
        end
        S_DIV_TRIAL: begin
          if (!last_trial) begin
            tmp_q[{k, 2'b00} +: 4] <= du_d;
            carry_q <= du_cout;
            cnt_q   <= cnt_q + 3'd1;
          end else begin
            cnt_q <= '0;
            // Quotient digits accumulate in acc_q's low digit; a borrow discards the trial
            if (du_cout) begin
              dig_q <= dig_q - 2'd1;
            end else begin
              rem_q       <= {du_d, tmp_q};
              acc_q[3:0]  <= acc_q[3:0] + 4'd1;
            end
          end
        end
        S_DONE: begin
          res_h <= acc_q;
          rem_h <= (op_q == OP_DIV) ? rem_q[15:0] : '0;
          neg_h <= neg_q;
          ovf_h <= ovf_q;
          err_h <= err_q;
        end
        default: ;
      endcase
    end
  end

  // During DONE the working registers already hold the final values; the hold copies take over after
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = done ? acc_q : res_h;
  assign remainder = done ? ((op_q == OP_DIV) ? rem_q[15:0] : '0) : rem_h;
  assign neg       = done ? neg_q : neg_h;
  assign ovf       = done ? ovf_q : ovf_h;
  assign err       = done ? err_q : err_h;

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Self-checking bench for bcd_alu_seq: directed test-plan cases plus randomized ops against an
// integer-arithmetic reference model.
module tb_bcd_alu_seq;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [15:0] bcd_a = '0, bcd_b = '0;
  logic        busy, done, neg, ovf, err;
  logic [15:0] result, remainder;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bcd_alu_seq dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .start     (start),
    .opcode    (opcode),
    .bcd_a     (bcd_a),
    .bcd_b     (bcd_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .remainder (remainder),
    .neg       (neg),
    .ovf       (ovf),
    .err       (err)
  );

  logic [34:0] g_out;
  logic [15:0] g_pre;
  logic        g_hs;
  int          g_cyc;

  logic [34:0] e_out;
  int          e_cyc;

  function automatic int dec(input logic [15:0] v);
    return 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] enc(input int x);
    return {4'(x / 1000 % 10), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [15:0] v);
    return (v[3:0] < 10) && (v[7:4] < 10) && (v[11:8] < 10) && (v[15:12] < 10);
  endfunction

  function automatic int dsum(input int x);
    return x % 10 + x / 10 % 10 + x / 100 % 10 + x / 1000 % 10;
  endfunction

  // Expected {result, remainder, neg, ovf, err} and done cycle from plain arithmetic
  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int av, bv, t, q, s;
    logic [15:0] r, rm;
    logic ng, ov;
    r = '0; rm = '0; ng = 1'b0; ov = 1'b0; s = 0;
    if (op < 10 || op > 13 || !bcd_ok(a) || !bcd_ok(b) || (op == 13 && b == 16'h0000)) begin
      e_out = {32'h0, 3'b001};
      e_cyc = 2;
      return;
    end
    av = dec(a);
    bv = dec(b);
    case (op)
      4'd10: begin t = av + bv; ov = (t > 9999); r = enc(t % 10000); s = 4; end
      4'd11: begin
        if (av >= bv) begin r = enc(av - bv); s = 4; end
        else begin r = enc(bv - av); ng = 1'b1; s = 8; end
      end
      4'd12: begin t = av * bv; ov = (t > 9999); r = enc(t % 10000); s = 4 + 4 * dsum(bv); end
      default: begin
        q = av / bv; r = enc(q); rm = enc(av % bv);
        s = 4 + 5 * (dsum(q) + 4);
      end
    endcase
    e_out = {r, rm, ng, ov, 1'b0};
    e_cyc = s + 2;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic busy0;
    @(negedge clk);
    opcode = op; bcd_a = a; bcd_b = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    g_pre = result;
    busy0 = busy;
    g_cyc = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin g_cyc = n + 1; break; end
    end
    g_out = {result, remainder, neg, ovf, err};
    @(posedge clk);
    #1 g_hs = (busy0 === 1'b1) && (done === 1'b0) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, result, remainder, neg, ovf, err} !== 37'h0)
      $display("FAIL reset_outputs got %h want 0", {busy, done, result, remainder, neg, ovf, err});
    else passed++;
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
  endtask

  task automatic test_add();
    run_op(4'd10, 16'h0045, 16'h0078);
    checks++; if (g_cyc !== 6) $display("FAIL add_latency got %0d want 6", g_cyc); else passed++;
    checks++; if (g_out !== {16'h0123, 16'h0000, 3'b000})
      $display("FAIL add_out got %h want %h", g_out, {16'h0123, 16'h0000, 3'b000}); else passed++;
    checks++; if (g_hs !== 1'b1) $display("FAIL add_handshake got %b want 1", g_hs); else passed++;
    run_op(4'd10, 16'h9999, 16'h0001);
    checks++; if (g_pre !== 16'h0123) $display("FAIL hold_result got %h want 0123", g_pre); else passed++;
    checks++; if (g_out !== {16'h0000, 16'h0000, 3'b010})
      $display("FAIL add_ovf got %h want %h", g_out, {16'h0000, 16'h0000, 3'b010}); else passed++;
  endtask

  task automatic test_sub();
    run_op(4'd11, 16'h0012, 16'h0045);
    checks++; if (g_cyc !== 10) $display("FAIL sub_neg_latency got %0d want 10", g_cyc); else passed++;
    checks++; if (g_out !== {16'h0033, 16'h0000, 3'b100})
      $display("FAIL sub_neg_out got %h want %h", g_out, {16'h0033, 16'h0000, 3'b100}); else passed++;
    run_op(4'd11, 16'h0045, 16'h0012);
    checks++; if (g_cyc !== 6) $display("FAIL sub_pos_latency got %0d want 6", g_cyc); else passed++;
    checks++; if (g_out !== {16'h0033, 16'h0000, 3'b000})
      $display("FAIL sub_pos_out got %h want %h", g_out, {16'h0033, 16'h0000, 3'b000}); else passed++;
  endtask

  task automatic test_mul();
    run_op(4'd12, 16'h0012, 16'h0003);
    checks++; if (g_cyc !== 18) $display("FAIL mul_latency got %0d want 18", g_cyc); else passed++;
    checks++; if (g_out !== {16'h0036, 16'h0000, 3'b000})
      $display("FAIL mul_out got %h want %h", g_out, {16'h0036, 16'h0000, 3'b000}); else passed++;
    run_op(4'd12, 16'h5000, 16'h0003);
    checks++; if (g_out !== {16'h5000, 16'h0000, 3'b010})
      $display("FAIL mul_ovf got %h want %h", g_out, {16'h5000, 16'h0000, 3'b010}); else passed++;
  endtask

  task automatic test_div();
    run_op(4'd13, 16'h0100, 16'h0007);
    checks++; if (g_cyc !== 51) $display("FAIL div_latency got %0d want 51", g_cyc); else passed++;
    checks++; if (g_out !== {16'h0014, 16'h0002, 3'b000})
      $display("FAIL div_out got %h want %h", g_out, {16'h0014, 16'h0002, 3'b000}); else passed++;
    run_op(4'd13, 16'h0005, 16'h0000);
    checks++; if (g_cyc !== 2) $display("FAIL div0_latency got %0d want 2", g_cyc); else passed++;
    checks++; if (g_out !== {16'h0000, 16'h0000, 3'b001})
      $display("FAIL div0_out got %h want %h", g_out, {16'h0000, 16'h0000, 3'b001}); else passed++;
  endtask

  task automatic test_err();
    run_op(4'd14, 16'h0001, 16'h0001);
    checks++; if (g_cyc !== 2) $display("FAIL badop_latency got %0d want 2", g_cyc); else passed++;
    checks++; if (g_out !== {16'h0000, 16'h0000, 3'b001})
      $display("FAIL badop_out got %h want %h", g_out, {16'h0000, 16'h0000, 3'b001}); else passed++;
    run_op(4'd10, 16'h00A1, 16'h0001);
    checks++; if (g_cyc !== 2) $display("FAIL baddigit_latency got %0d want 2", g_cyc); else passed++;
    checks++; if (g_out !== {16'h0000, 16'h0000, 3'b001})
      $display("FAIL baddigit_out got %h want %h", g_out, {16'h0000, 16'h0000, 3'b001}); else passed++;
  endtask

  task automatic test_busy_ignore();
    int nd, cyc;
    logic [34:0] got;
    nd = 0; cyc = -1; got = '0;
    @(negedge clk);
    opcode = 4'd12; bcd_a = 16'h0012; bcd_b = 16'h0003; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = (n == 4) || (n == 9);
      if (n == 4) begin opcode = 4'd10; bcd_a = 16'h0001; bcd_b = 16'h0001; end
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        nd++;
        if (nd == 1) begin cyc = n + 1; got = {result, remainder, neg, ovf, err}; end
      end
    end
    @(negedge clk) start = 1'b0;
    checks++; if (nd !== 1) $display("FAIL busy_done_count got %0d want 1", nd); else passed++;
    checks++; if (cyc !== 18) $display("FAIL busy_latency got %0d want 18", cyc); else passed++;
    checks++; if (got !== {16'h0036, 16'h0000, 3'b000})
      $display("FAIL busy_out got %h want %h", got, {16'h0036, 16'h0000, 3'b000}); else passed++;
  endtask

  task automatic test_abort();
    int nd;
    nd = 0;
    @(negedge clk);
    opcode = 4'd12; bcd_a = 16'h0012; bcd_b = 16'h0003; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 clear_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, remainder, neg, ovf, err} !== 37'h0)
      $display("FAIL abort_outputs got %h want 0", {busy, done, result, remainder, neg, ovf, err});
    else passed++;
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    checks++; if (nd !== 0) $display("FAIL abort_no_done got %0d active cycles want 0", nd); else passed++;
    run_op(4'd10, 16'h0001, 16'h0001);
    checks++; if (g_cyc !== 6) $display("FAIL abort_add_latency got %0d want 6", g_cyc); else passed++;
    checks++; if (g_out !== {16'h0002, 16'h0000, 3'b000})
      $display("FAIL abort_add_out got %h want %h", g_out, {16'h0002, 16'h0000, 3'b000}); else passed++;
  endtask

  function automatic logic [15:0] rnd_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 2) == 0) v[15:8] = '0;
    if ($urandom_range(0, 15) == 0) v[7:4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  task automatic test_random();
    logic [3:0] op;
    logic [15:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'(10 + $urandom_range(0, 3));
      a = rnd_bcd();
      b = rnd_bcd();
      model(op, a, b);
      run_op(op, a, b);
      checks++;
      if (g_cyc !== e_cyc) $display("FAIL rand_latency op=%0d a=%h b=%h got %0d want %0d", op, a, b, g_cyc, e_cyc);
      else passed++;
      checks++;
      if (g_out !== e_out) $display("FAIL rand_out op=%0d a=%h b=%h got %h want %h", op, a, b, g_out, e_out);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_err();
    test_busy_ignore();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
